// File: rtl/axi_burst_splitter_ax_seq.sv
// rtl/axi_burst_splitter_ax_seq.sv - splits one AXI address-channel burst into single-beat transactions
module axi_burst_splitter_ax_seq #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdWidth   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [IdWidth-1:0]   slv_ax_id_i,
    input  logic [AddrWidth-1:0] slv_ax_addr_i,
    input  logic [7:0]           slv_ax_len_i,
    input  logic [2:0]           slv_ax_size_i,
    input  logic [1:0]           slv_ax_burst_i,
    input  logic                 slv_ax_valid_i,
    output logic                 slv_ax_ready_o,
    output logic [IdWidth-1:0]   mst_ax_id_o,
    output logic [AddrWidth-1:0] mst_ax_addr_o,
    output logic [7:0]           mst_ax_len_o,
    output logic [2:0]           mst_ax_size_o,
    output logic [1:0]           mst_ax_burst_o,
    output logic                 mst_ax_valid_o,
    input  logic                 mst_ax_ready_i,
    output logic [IdWidth-1:0]   cnt_alloc_id_o,
    output logic [7:0]           cnt_alloc_len_o,
    output logic                 cnt_alloc_req_o,
    input  logic                 cnt_alloc_gnt_i
);

    localparam logic [AddrWidth-1:0] One = AddrWidth'(1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                 state_q, state_d;
    logic [IdWidth-1:0]     id_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [7:0]             len_q;
    logic [2:0]             size_q;
    logic [1:0]             burst_q;
    logic [7:0]             rem_q;

    logic                   load;
    logic                   advance;
    logic [7:0]             len_fill;
    logic [AddrWidth-1:0]   bytes;
    logic [AddrWidth-1:0]   wrap_mask;
    logic [AddrWidth-1:0]   addr_next;

    // Next beat address; an illegal WRAP length is rounded up to the next power-of-two span
    always_comb begin
        bytes     = One << size_q;
        len_fill  = len_q | (len_q >> 1);
        len_fill  = len_fill | (len_fill >> 2);
        len_fill  = len_fill | (len_fill >> 4);
        wrap_mask = (AddrWidth'(len_fill) << size_q) | (bytes - One);
        case (burst_q)
            2'b00:   addr_next = addr_q;
            2'b10:   addr_next = (addr_q & ~wrap_mask) | ((addr_q + bytes) & wrap_mask);
            default: addr_next = (addr_q & ~(bytes - One)) + bytes;
        endcase
    end

    // Next-state and handshake decode; alloc and slave accept share one condition
    always_comb begin
        state_d         = state_q;
        slv_ax_ready_o  = 1'b0;
        cnt_alloc_req_o = 1'b0;
        mst_ax_valid_o  = 1'b0;
        load            = 1'b0;
        advance         = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_alloc_req_o = slv_ax_valid_i;
                slv_ax_ready_o  = slv_ax_valid_i & cnt_alloc_gnt_i;
                if (slv_ax_valid_i && cnt_alloc_gnt_i) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                mst_ax_valid_o = 1'b1;
                if (mst_ax_ready_i) begin
                    if (rem_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and burst context registers; beat fields only move on a downstream handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                id_q    <= slv_ax_id_i;
                addr_q  <= slv_ax_addr_i;
                len_q   <= slv_ax_len_i;
                size_q  <= slv_ax_size_i;
                burst_q <= slv_ax_burst_i;
                rem_q   <= slv_ax_len_i;
            end else if (advance) begin
                rem_q  <= rem_q - 8'd1;
                addr_q <= addr_next;
            end
        end
    end

    assign mst_ax_id_o     = id_q;
    assign mst_ax_addr_o   = addr_q;
    assign mst_ax_len_o    = 8'd0;
    assign mst_ax_size_o   = size_q;
    assign mst_ax_burst_o  = 2'b01;
    assign cnt_alloc_id_o  = slv_ax_id_i;
    assign cnt_alloc_len_o = slv_ax_len_i;

endmodule

// File: tb/tb_axi_burst_splitter_ax_seq.sv
// tb/tb_axi_burst_splitter_ax_seq.sv - randomized self-checking bench for axi_burst_splitter_ax_seq
module tb_axi_burst_splitter_ax_seq;

    logic        clk;
    logic        rst_n;
    logic [3:0]  slv_id;
    logic [63:0] slv_addr;
    logic [7:0]  slv_len;
    logic [2:0]  slv_size;
    logic [1:0]  slv_burst;
    logic        slv_valid;
    logic        slv_ready;
    logic [3:0]  mst_id;
    logic [63:0] mst_addr;
    logic [7:0]  mst_len;
    logic [2:0]  mst_size;
    logic [1:0]  mst_burst;
    logic        mst_valid;
    logic        mst_ready;
    logic [3:0]  alloc_id;
    logic [7:0]  alloc_len;
    logic        alloc_req;
    logic        gnt;

    axi_burst_splitter_ax_seq #(.AddrWidth(64), .IdWidth(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_ax_id_i(slv_id), .slv_ax_addr_i(slv_addr), .slv_ax_len_i(slv_len),
        .slv_ax_size_i(slv_size), .slv_ax_burst_i(slv_burst),
        .slv_ax_valid_i(slv_valid), .slv_ax_ready_o(slv_ready),
        .mst_ax_id_o(mst_id), .mst_ax_addr_o(mst_addr), .mst_ax_len_o(mst_len),
        .mst_ax_size_o(mst_size), .mst_ax_burst_o(mst_burst),
        .mst_ax_valid_o(mst_valid), .mst_ax_ready_i(mst_ready),
        .cnt_alloc_id_o(alloc_id), .cnt_alloc_len_o(alloc_len),
        .cnt_alloc_req_o(alloc_req), .cnt_alloc_gnt_i(gnt)
    );

    typedef struct {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [2:0]  size;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] beat_log[$];
    int          checks = 0;
    int          failures = 0;
    bit          ready_mode = 0;
    bit          gnt_rand = 0;
    logic [7:0]  last_alloc_len;

    bit          stall_prev = 0;
    logic [3:0]  prev_id;
    logic [63:0] prev_addr;
    logic [2:0]  prev_size;

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
        end
    endfunction

    // Reference: beat i address from closed-form burst arithmetic
    function automatic void push_beats(input logic [3:0] id, input logic [63:0] addr,
                                       input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic [63:0] bytes, pow, span, a, off;
        bytes = 64'd1 << size;
        pow = 1;
        while (pow < 64'(len) + 1) pow = pow * 2;
        span = pow * bytes;
        off = addr % span;
        for (int i = 0; i <= int'(len); i++) begin
            if (burst == 2'd0) a = addr;
            else if (burst == 2'd2) a = (addr - off) + ((off + 64'(i) * bytes) % span);
            else if (i == 0) a = addr;
            else a = (addr - (addr % bytes)) + 64'(i) * bytes;
            exp_q.push_back('{id: id, addr: a, size: size});
        end
    endfunction

    always @(posedge clk) begin
        #1;
        mst_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process: DUT outputs against the model every cycle, mid-period
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 0;
            chk("reset_mst_valid", 64'(mst_valid), 0);
        end else begin
            chk("slv_ready", 64'(slv_ready), 64'(exp_q.size() == 0 && slv_valid && gnt));
            chk("alloc_req", 64'(alloc_req), 64'(exp_q.size() == 0 && slv_valid));
            if (slv_valid && slv_ready) begin
                chk("alloc_id", 64'(alloc_id), 64'(slv_id));
                chk("alloc_len", 64'(alloc_len), 64'(slv_len));
            end
            chk("mst_valid", 64'(mst_valid), 64'(exp_q.size() != 0));
            if (mst_valid && exp_q.size() != 0) begin
                chk("mst_addr", mst_addr, exp_q[0].addr);
                chk("mst_id", 64'(mst_id), 64'(exp_q[0].id));
                chk("mst_size", 64'(mst_size), 64'(exp_q[0].size));
                chk("mst_len", 64'(mst_len), 0);
                chk("mst_burst", 64'(mst_burst), 1);
            end
            if (stall_prev) begin
                chk("stable_valid", 64'(mst_valid), 1);
                chk("stable_addr", mst_addr, prev_addr);
                chk("stable_id", 64'(mst_id), 64'(prev_id));
                chk("stable_size", 64'(mst_size), 64'(prev_size));
            end
            if (mst_valid && mst_ready && exp_q.size() != 0) begin
                beat_log.push_back(mst_addr);
                void'(exp_q.pop_front());
            end
            if (slv_valid && slv_ready) push_beats(slv_id, slv_addr, slv_len, slv_size, slv_burst);
            stall_prev = mst_valid && !mst_ready;
            prev_id = mst_id;
            prev_addr = mst_addr;
            prev_size = mst_size;
        end
    end

    task automatic send_burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        bit done = 0;
        @(posedge clk); #1;
        slv_id = id; slv_addr = addr; slv_len = len; slv_size = size; slv_burst = burst;
        slv_valid = 1;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            if (slv_ready) begin
                done = 1;
                last_alloc_len = alloc_len;
            end
            @(posedge clk); #1;
            if (!done && gnt_rand) gnt = 1'($urandom_range(0, 1));
        end
        slv_valid = 0;
        gnt = 1;
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mst_valid) done = 1;
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    task automatic check_log(input string nm, input logic [63:0] e[$]);
        chk({nm, "_count"}, 64'(beat_log.size()), 64'(e.size()));
        for (int i = 0; i < e.size() && i < beat_log.size(); i++) chk(nm, beat_log[i], e[i]);
    endtask

    initial begin
        logic [63:0] e[$];
        int cnt;
        bit seen;
        rst_n = 0; slv_valid = 0; slv_id = 0; slv_addr = 0; slv_len = 0; slv_size = 0;
        slv_burst = 0; gnt = 1; mst_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_addr", mst_addr, 0);
        chk("rst_id", 64'(mst_id), 0);
        chk("rst_size", 64'(mst_size), 0);
        chk("rst_len", 64'(mst_len), 0);
        chk("rst_burst", 64'(mst_burst), 1);
        chk("rst_ready", 64'(slv_ready), 0);

        // INCR with unaligned start
        beat_log.delete();
        send_burst(4'd1, 64'h1002, 8'd3, 3'd2, 2'd1);
        wait_idle();
        e = '{64'h1002, 64'h1004, 64'h1008, 64'h100C};
        check_log("incr", e);

        // WRAP
        beat_log.delete();
        send_burst(4'd2, 64'h1008, 8'd3, 3'd2, 2'd2);
        wait_idle();
        e = '{64'h1008, 64'h100C, 64'h1000, 64'h1004};
        check_log("wrap", e);

        // FIXED
        beat_log.delete();
        send_burst(4'd3, 64'h40, 8'd2, 3'd3, 2'd0);
        wait_idle();
        chk("fixed_alloc_len", 64'(last_alloc_len), 2);
        e = '{64'h40, 64'h40, 64'h40};
        check_log("fixed", e);

        // Valid dropping without grant, then a 10-cycle grant stall
        cnt = 0;
        @(posedge clk); #1;
        gnt = 0; slv_id = 4'd5; slv_addr = 64'h80; slv_len = 8'd1; slv_size = 3'd2;
        slv_burst = 2'd1; slv_valid = 1;
        repeat (3) begin @(negedge clk); if (slv_ready || mst_valid) cnt++; end
        @(posedge clk); #1 slv_valid = 0;
        repeat (2) begin @(negedge clk); if (slv_ready || mst_valid) cnt++; end
        @(posedge clk); #1 slv_valid = 1;
        repeat (10) begin @(negedge clk); if (slv_ready || mst_valid) cnt++; end
        chk("stall_activity", 64'(cnt), 0);
        @(posedge clk); #1 gnt = 1;
        @(negedge clk);
        chk("stall_accept", 64'(slv_ready), 1);
        @(posedge clk); #1 slv_valid = 0;
        @(negedge clk);
        chk("stall_first_beat", 64'(mst_valid), 1);
        wait_idle();

        // 256-beat INCR with random downstream backpressure
        ready_mode = 1;
        beat_log.delete();
        send_burst(4'd6, 64'hFF, 8'd255, 3'd0, 2'd1);
        wait_idle();
        chk("len255_count", 64'(beat_log.size()), 256);
        if (beat_log.size() == 256) chk("len255_last", beat_log[255], 64'h1FE);
        ready_mode = 0;

        // Reset in the middle of a burst
        beat_log.delete();
        send_burst(4'd7, 64'h200, 8'd7, 3'd3, 2'd1);
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (beat_log.size() >= 2) seen = 1;
        end
        if (!seen) chk("reset_wait_timeout", 0, 1);
        @(posedge clk); #1 rst_n = 0;
        #1 chk("reset_immediate", 64'(mst_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        beat_log.delete();
        send_burst(4'd8, 64'h300, 8'd0, 3'd2, 2'd1);
        wait_idle();
        e = '{64'h300};
        check_log("post_reset", e);

        // Randomized back-to-back bursts
        gnt_rand = 1;
        for (int b = 0; b < 40; b++) begin
            ready_mode = 1'($urandom_range(0, 1));
            send_burst(4'($urandom), {$urandom, $urandom}, 8'($urandom_range(0, 15)),
                       3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end
        wait_idle();
        gnt_rand = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
